// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker and its read engine.
package sysid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_ID,
      ST_WAIT_ID,
      ST_REQ_TS,
      ST_WAIT_TS,
      ST_DONE
   } state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
   localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h6037_6792;

endpackage

// File: rtl/avm_single_read.sv
// Avalon-MM single-read engine: request/accept/valid qualification plus a
// per-transaction down-counting timeout with terminal-count compare.
module avm_single_read #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic        req,
   input  logic        wait_rsp,
   input  logic        addr,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        accepted,
   output logic        valid,
   output logic        expired,
   output logic [31:0] rd_data
);

   localparam int            CW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] tmr;
   logic          active;

   assign active = req | wait_rsp;

   // Loaded with N-1 so the terminal count is seen on the N-th active cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmr <= '0;
      end else if (load) begin
         tmr <= TC_LOAD;
      end else if (active && (tmr != '0)) begin
         tmr <= tmr - CW'(1);
      end
   end

   assign avm_read    = req;
   assign avm_address = addr;
   assign accepted    = req & ~avm_waitrequest;
   assign valid       = wait_rsp & avm_readdatavalid;
   assign expired     = active & (tmr == '0);
   assign rd_data     = avm_readdata;

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID slave (ID word, then build timestamp) and flags
// whether both match the expected build values, or whether a read timed out.
//
//   state      | meaning
//   -----------+------------------------------------------------
//   ST_IDLE    | waiting for start or the post-reset auto check
//   ST_REQ_ID  | read of word 0 presented, waiting for acceptance
//   ST_WAIT_ID | word 0 accepted, waiting for readdatavalid
//   ST_REQ_TS  | read of word 1 presented, waiting for acceptance
//   ST_WAIT_TS | word 1 accepted, waiting for readdatavalid
//   ST_DONE    | results held until the next start
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   state_t      state, state_nx;
   logic        auto_pend;
   logic        load, clr, cap_id, cap_ts, set_tmo;
   logic        req, wait_rsp, eng_addr;
   logic        accepted, valid, expired;
   logic [31:0] rd_data;

   avm_single_read #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_read (
      .clock             (clock),
      .reset_n           (reset_n),
      .load              (load),
      .req               (req),
      .wait_rsp          (wait_rsp),
      .addr              (eng_addr),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .accepted          (accepted),
      .valid             (valid),
      .expired           (expired),
      .rd_data           (rd_data)
   );

   assign req      = (state == ST_REQ_ID)  || (state == ST_REQ_TS);
   assign wait_rsp = (state == ST_WAIT_ID) || (state == ST_WAIT_TS);
   assign eng_addr = ((state == ST_REQ_TS) || (state == ST_WAIT_TS)) ? SYSID_ADDR_TS
                                                                     : SYSID_ADDR_ID;
   assign busy     = req | wait_rsp;
   assign done     = (state == ST_DONE);

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      clr      = 1'b0;
      cap_id   = 1'b0;
      cap_ts   = 1'b0;
      set_tmo  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start || ((state == ST_IDLE) && auto_pend)) begin
               state_nx = ST_REQ_ID;
               load     = 1'b1;
               clr      = 1'b0 | 1'b1;
            end
         end
         ST_REQ_ID: begin
            if (expired) begin
               state_nx = ST_DONE;
               set_tmo  = 1'b1;
            end else if (accepted) begin
               state_nx = ST_WAIT_ID;
            end
         end
         // Data beats expiry when both land in the same cycle.
         ST_WAIT_ID: begin
            if (valid) begin
               state_nx = ST_REQ_TS;
               load     = 1'b1;
               cap_id   = 1'b1;
            end else if (expired) begin
               state_nx = ST_DONE;
               set_tmo  = 1'b1;
            end
         end
         ST_REQ_TS: begin
            if (expired) begin
               state_nx = ST_DONE;
               set_tmo  = 1'b1;
            end else if (accepted) begin
               state_nx = ST_WAIT_TS;
            end
         end
         ST_WAIT_TS: begin
            if (valid) begin
               state_nx = ST_DONE;
               cap_ts   = 1'b1;
            end else if (expired) begin
               state_nx = ST_DONE;
               set_tmo  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         auto_pend <= AUTO_START;
         id_ok     <= 1'b0;
         ts_ok     <= 1'b0;
         timeout   <= 1'b0;
         id_value  <= '0;
         ts_value  <= '0;
      end else begin
         state     <= state_nx;
         auto_pend <= 1'b0;
         if (clr) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
         end
         if (cap_id) begin
            id_value <= rd_data;
            id_ok    <= (rd_data == EXPECTED_ID);
         end
         if (cap_ts) begin
            ts_value <= rd_data;
            ts_ok    <= (rd_data == EXPECTED_TS);
         end
         if (set_tmo) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule
